// File: rtl/if_fetch_pkg.sv
// Shared constants, FSM state encoding and PC helper for the instruction fetch unit.
package if_fetch_pkg;

   localparam logic [31:0] INST_NOP     = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_SKID = 2'd3
   } state_t;

   // Sequential PC step; wraps modulo 2^32 by construction.
   function automatic logic [31:0] pc_inc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Output register toward if_id plus a one-entry skid that absorbs a word
// returned while the downstream stage is held.
module if_fetch_buf
   import if_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        hold,
   input  logic        wr_en,
   input  logic [31:0] wr_inst,
   input  logic [31:0] wr_addr,
   output logic [31:0] inst,
   output logic [31:0] inst_addr,
   output logic        inst_valid,
   output logic        slot_free,
   output logic        skid_valid
);

   logic        consume;
   logic [31:0] skid_inst;
   logic [31:0] skid_addr;

   assign consume   = inst_valid && !hold;
   assign slot_free = !inst_valid || consume;

   // Priority: flush, new memory data, skid drain, plain consume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inst       <= INST_NOP;
         inst_addr  <= 32'h0;
         inst_valid <= 1'b0;
         skid_valid <= 1'b0;
         skid_inst  <= INST_NOP;
         skid_addr  <= 32'h0;
      end else if (flush) begin
         inst       <= INST_NOP;
         inst_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (wr_en) begin
         if (slot_free) begin
            inst       <= wr_inst;
            inst_addr  <= wr_addr;
            inst_valid <= 1'b1;
         end else begin
            skid_inst  <= wr_inst;
            skid_addr  <= wr_addr;
            skid_valid <= 1'b1;
         end
      end else if (skid_valid && slot_free) begin
         inst       <= skid_inst;
         inst_addr  <= skid_addr;
         inst_valid <= 1'b1;
         skid_valid <= 1'b0;
      end else if (consume) begin
         inst       <= INST_NOP;
         inst_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, single-outstanding req/gnt/rvalid fetches.
// Define IF_MISALIGN_EN to word-align jump targets and pulse misalign_o.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_flag_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_gnt_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o,
   output logic        inst_valid_o,
   output state_t      dbg_state
`ifdef IF_MISALIGN_EN
   ,output logic       misalign_o
`endif
);

   // Handshake: a request is accepted on a cycle with imem_req_o && imem_gnt_i;
   // its data arrives later on one imem_rvalid_i cycle; rvalid outside S_WAIT is ignored.

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] req_addr_q, req_addr_d;
   logic        discard_q, discard_d;
   logic        wr_en;
   logic        slot_free;
   logic        skid_valid;
   logic [31:0] jump_tgt;

`ifdef IF_MISALIGN_EN
   assign jump_tgt = {jump_addr_i[31:2], 2'b00};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) misalign_o <= 1'b0;
      else     misalign_o <= jump_flag_i && (jump_addr_i[1:0] != 2'b00);
   end
`else
   assign jump_tgt = jump_addr_i;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pc_q       <= RESET_PC;
         req_addr_q <= RESET_PC;
         discard_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_addr_q <= req_addr_d;
         discard_q  <= discard_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      discard_d  = discard_q;
      wr_en      = 1'b0;
      if (jump_flag_i) pc_d = jump_tgt;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (imem_gnt_i) begin
               state_d = S_WAIT;
               // A grant coinciding with a jump fetches the old PC; its data must die.
               if (jump_flag_i) begin
                  discard_d = 1'b1;
               end else begin
                  req_addr_d = pc_q;
                  pc_d       = pc_inc(pc_q);
               end
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               discard_d = 1'b0;
               if (jump_flag_i || discard_q) begin
                  state_d = S_REQ;
               end else begin
                  wr_en   = 1'b1;
                  state_d = slot_free ? S_REQ : S_SKID;
               end
            end else if (jump_flag_i) begin
               discard_d = 1'b1;
            end
         end
         S_SKID: begin
            if (jump_flag_i || slot_free) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req_o  = (state_q == S_REQ);
   assign imem_addr_o = pc_q;
   assign dbg_state   = state_q;

   if_fetch_buf u_buf (
      .clk        (clk),
      .rst        (rst),
      .flush      (jump_flag_i),
      .hold       (hold_flag_i),
      .wr_en      (wr_en),
      .wr_inst    (imem_rdata_i),
      .wr_addr    (req_addr_q),
      .inst       (inst_o),
      .inst_addr  (inst_addr_o),
      .inst_valid (inst_valid_o),
      .slot_free  (slot_free),
      .skid_valid (skid_valid)
   );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: per-cycle vectors driven on the falling edge,
// outputs checked on the falling edge against hand-computed values.
module tb_if_fetch;
   import if_fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic        jump_flag_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;
   state_t      dbg_state;
`ifdef IF_MISALIGN_EN
   logic        misalign_o;
`endif

   int errors = 0;
   int checks = 0;

   if_fetch dut (
      .clk           (clk),
      .rst           (rst),
      .jump_flag_i   (jump_flag_i),
      .jump_addr_i   (jump_addr_i),
      .hold_flag_i   (hold_flag_i),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .inst_o        (inst_o),
      .inst_addr_o   (inst_addr_o),
      .inst_valid_o  (inst_valid_o),
      .dbg_state     (dbg_state)
`ifdef IF_MISALIGN_EN
      ,.misalign_o   (misalign_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                        input logic h, input logic j, input logic [31:0] ja);
      imem_gnt_i    = g;
      imem_rvalid_i = rv;
      imem_rdata_i  = rd;
      hold_flag_i   = h;
      jump_flag_i   = j;
      jump_addr_i   = ja;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   {31'b0, imem_req_o},   32'h0);
      check({tag, "_iaddr"}, imem_addr_o,           32'h0);
      check({tag, "_inst"},  inst_o,                INST_NOP);
      check({tag, "_addr"},  inst_addr_o,           32'h0);
      check({tag, "_valid"}, {31'b0, inst_valid_o}, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      #1;
      check_reset_outputs("rst0");
      check("rst0_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
      #1 rst = 1'b0;

      // cycle 1: first request to RESET_PC
      @(negedge clk);
      check("c1_req",   {31'b0, imem_req_o}, 32'h1);
      check("c1_iaddr", imem_addr_o, 32'h0);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      // cycle 2: waiting, zero-wait data
      @(negedge clk);
      check("c2_req",   {31'b0, imem_req_o}, 32'h0);
      check("c2_state", {30'b0, dbg_state}, {30'b0, S_WAIT});
      drive(0, 1, 32'h0050_0093, 0, 0, 32'h0);
      // cycle 3: first instruction presented, next request to 0x4; hold begins
      @(negedge clk);
      check("c3_inst",  inst_o, 32'h0050_0093);
      check("c3_addr",  inst_addr_o, 32'h0);
      check("c3_valid", {31'b0, inst_valid_o}, 32'h1);
      check("c3_iaddr", imem_addr_o, 32'h4);
      drive(1, 0, 32'h0, 1, 0, 32'h0);
      // cycle 4: second word returns while held
      @(negedge clk);
      check("c4_req", {31'b0, imem_req_o}, 32'h0);
      drive(0, 1, 32'h0000_0113, 1, 0, 32'h0);
      // cycles 5-6: skid occupied, no request, output stable
      @(negedge clk);
      check("c5_state", {30'b0, dbg_state}, {30'b0, S_SKID});
      check("c5_req",   {31'b0, imem_req_o}, 32'h0);
      check("c5_inst",  inst_o, 32'h0050_0093);
      check("c5_valid", {31'b0, inst_valid_o}, 32'h1);
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      @(negedge clk);
      check("c6_req",  {31'b0, imem_req_o}, 32'h0);
      check("c6_addr", inst_addr_o, 32'h0);
      drive(0, 0, 32'h0, 1, 0, 32'h0);
      // cycle 7: release hold
      @(negedge clk);
      check("c7_addr",  inst_addr_o, 32'h0);
      check("c7_valid", {31'b0, inst_valid_o}, 32'h1);
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      // cycle 8: skid word moved to output, fetch resumes at 0x8
      @(negedge clk);
      check("c8_inst",  inst_o, 32'h0000_0113);
      check("c8_addr",  inst_addr_o, 32'h4);
      check("c8_req",   {31'b0, imem_req_o}, 32'h1);
      check("c8_iaddr", imem_addr_o, 32'h8);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      // cycle 9: consumed with nothing new -> NOP; jump to 0x100 while waiting
      @(negedge clk);
      check("c9_valid", {31'b0, inst_valid_o}, 32'h0);
      check("c9_inst",  inst_o, INST_NOP);
      drive(0, 0, 32'h0, 0, 1, 32'h0000_0100);
      // cycle 10: stale data for 0x8 arrives and must be dropped
      @(negedge clk);
      check("c10_req", {31'b0, imem_req_o}, 32'h0);
      drive(0, 1, 32'hDEAD_BEEF, 0, 0, 32'h0);
      // cycle 11: request to jump target
      @(negedge clk);
      check("c11_valid", {31'b0, inst_valid_o}, 32'h0);
      check("c11_inst",  inst_o, INST_NOP);
      check("c11_req",   {31'b0, imem_req_o}, 32'h1);
      check("c11_iaddr", imem_addr_o, 32'h100);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      // cycle 12: jump to 0x200 together with rvalid
      @(negedge clk);
      drive(0, 1, 32'h1234_5678, 0, 1, 32'h0000_0200);
      @(negedge clk);
      check("c13_valid", {31'b0, inst_valid_o}, 32'h0);
      check("c13_req",   {31'b0, imem_req_o}, 32'h1);
      check("c13_iaddr", imem_addr_o, 32'h200);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      @(negedge clk);
      drive(0, 1, 32'h00A0_0193, 0, 0, 32'h0);
      // cycle 15: target word presented; jump to 0x300 coinciding with a grant
      @(negedge clk);
      check("c15_inst",  inst_o, 32'h00A0_0193);
      check("c15_addr",  inst_addr_o, 32'h200);
      check("c15_iaddr", imem_addr_o, 32'h204);
      drive(1, 0, 32'h0, 0, 1, 32'h0000_0300);
      @(negedge clk);
      check("c16_valid", {31'b0, inst_valid_o}, 32'h0);
      check("c16_state", {30'b0, dbg_state}, {30'b0, S_WAIT});
      drive(0, 1, 32'h0000_0BAD, 0, 0, 32'h0);
      // cycle 17: discarded word dropped; jump without grant stays in S_REQ
      @(negedge clk);
      check("c17_valid", {31'b0, inst_valid_o}, 32'h0);
      check("c17_iaddr", imem_addr_o, 32'h300);
      drive(0, 0, 32'h0, 0, 1, 32'h0000_0400);
      @(negedge clk);
      check("c18_req",   {31'b0, imem_req_o}, 32'h1);
      check("c18_iaddr", imem_addr_o, 32'h400);
      drive(0, 0, 32'h0, 0, 1, 32'hFFFF_FFFC);
      // cycles 19-21: fetch at top of address space, PC wraps to 0
      @(negedge clk);
      check("c19_iaddr", imem_addr_o, 32'hFFFF_FFFC);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      @(negedge clk);
      drive(0, 1, 32'h1111_1111, 0, 0, 32'h0);
      @(negedge clk);
      check("c21_inst",  inst_o, 32'h1111_1111);
      check("c21_addr",  inst_addr_o, 32'hFFFF_FFFC);
      check("c21_iaddr", imem_addr_o, 32'h0);
      drive(1, 0, 32'h0, 0, 0, 32'h0);
      // cycle 22: asynchronous reset while in S_WAIT
      @(negedge clk);
      check("c22_state", {30'b0, dbg_state}, {30'b0, S_WAIT});
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      rst = 1'b1;
      #1;
      check_reset_outputs("arst");
      check("arst_state", {30'b0, dbg_state}, {30'b0, S_IDLE});
      @(negedge clk);
      check_reset_outputs("arst2");
      rst = 1'b0;
      drive(0, 1, 32'h0000_0BAD, 0, 0, 32'h0);
      // cycle 24: stray rvalid ignored, first request at RESET_PC
      @(negedge clk);
      check("c24_req",   {31'b0, imem_req_o}, 32'h1);
      check("c24_iaddr", imem_addr_o, 32'h0);
      check("c24_valid", {31'b0, inst_valid_o}, 32'h0);
      check("c24_inst",  inst_o, INST_NOP);
      drive(0, 0, 32'h0, 0, 1, 32'h0000_0102);
      // cycle 25: misaligned jump target
      @(negedge clk);
`ifdef IF_MISALIGN_EN
      check("c25_misalign", {31'b0, misalign_o}, 32'h1);
      check("c25_iaddr", imem_addr_o, 32'h100);
`else
      check("c25_iaddr", imem_addr_o, 32'h102);
`endif
      drive(0, 0, 32'h0, 0, 0, 32'h0);
      @(negedge clk);
`ifdef IF_MISALIGN_EN
      check("c26_misalign", {31'b0, misalign_o}, 32'h0);
      check("c26_iaddr", imem_addr_o, 32'h100);
`else
      check("c26_iaddr", imem_addr_o, 32'h102);
`endif
      check("c26_req", {31'b0, imem_req_o}, 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
